// File: rtl/ika87ad_mcseq_pkg.sv
// Shared definitions for the IKA87AD microcode sequencer: bus codes, microword
// field positions, micro-op types, sequencer states and the output decoder.
package ika87ad_mcseq_pkg;

  localparam logic [1:0] BUS_RD3 = 2'd0;
  localparam logic [1:0] BUS_RD4 = 2'd1;
  localparam logic [1:0] BUS_WR3 = 2'd2;
  localparam logic [1:0] BUS_WR4 = 2'd3;

  localparam int MW_WIDTH   = 18;
  localparam int MW_TYPE_HI = 17;
  localparam int MW_TYPE_LO = 16;
  localparam int MW_CTRL_HI = 15;
  localparam int MW_CTRL_LO = 2;
  localparam int MW_BUS_HI  = 1;
  localparam int MW_BUS_LO  = 0;
  localparam int UOP_WIDTH  = MW_TYPE_HI - MW_CTRL_LO + 1;

  localparam logic [2:0] STEP_MAX = 3'd7;

  typedef enum logic [1:0] {
    MCTYPE_NOP = 2'd0,
    MCTYPE_ALU = 2'd1,
    MCTYPE_MOV = 2'd2,
    MCTYPE_MEM = 2'd3
  } mctype_t;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ROMRD   = 3'd2,
    ST_ROMWAIT = 3'd3,
    ST_EXEC    = 3'd4,
    ST_BUSWAIT = 3'd5
  } state_t;

  typedef struct packed {
    logic       read_tick;
    logic       bus_req;
    logic [1:0] bus_type;
    logic       uop_valid;
    logic       busy;
  } out_t;

  // Strobe/request pattern seen while sitting in a given state.
  function automatic out_t decode_outputs(input state_t st, input logic [1:0] code);
    out_t o;
    o = '{read_tick: 1'b0, bus_req: 1'b0, bus_type: BUS_RD4, uop_valid: 1'b0, busy: 1'b0};
    case (st)
      ST_FETCH:   o.bus_req = 1'b1;
      ST_ROMRD:   begin o.read_tick = 1'b1; o.busy = 1'b1; end
      ST_ROMWAIT: o.busy = 1'b1;
      ST_EXEC:    begin o.uop_valid = 1'b1; o.busy = 1'b1; end
      ST_BUSWAIT: begin o.bus_req = 1'b1; o.bus_type = code; o.busy = 1'b1; end
      default:    ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ika87ad_mcseq.sv
// IKA87AD microcode sequencer: fetches opcodes, walks microwords from an external
// ROM and issues bus cycles. Define IKA87AD_MCSEQ_OVERRUN_TRAP_EN for the step-limit trap.
module ika87ad_mcseq
  import ika87ad_mcseq_pkg::*;
(
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_CEN,
  output logic        o_MCROM_READ_TICK,
  output logic [7:0]  o_MCROM_ADDR,
  input  logic [17:0] i_MCROM_DATA,
  output logic        o_BUS_REQ,
  output logic [1:0]  o_BUS_TYPE,
  input  logic        i_BUS_ACK,
  input  logic [7:0]  i_OPCODE,
  output logic [15:0] o_UOP,
  output logic        o_UOP_VALID,
  output logic        o_BUSY,
  output logic        o_MC_OVERRUN
);

  state_t                state, state_nxt;
  logic [7:0]            addr, addr_nxt;
  logic [MW_WIDTH-1:0]   mword, mword_nxt;
  logic [2:0]            step, step_nxt;
  logic                  ack_pend;
  logic [7:0]            op_hold;
  out_t                  outs_q;

  logic                  ack_eff;
  logic [7:0]            op_eff;
  logic                  bus_phase;
  logic [1:0]            bus_code;

  // An ack seen while i_CEN is low is parked here until the next tick.
  assign bus_phase = (state == ST_FETCH) || (state == ST_BUSWAIT);
  assign ack_eff   = i_BUS_ACK || ack_pend;
  assign op_eff    = ack_pend ? op_hold : i_OPCODE;
  assign bus_code  = mword[MW_BUS_HI:MW_BUS_LO];

`ifdef IKA87AD_MCSEQ_OVERRUN_TRAP_EN
  logic overrun_q, overrun_nxt;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    addr_nxt  = addr;
    mword_nxt = mword;
    step_nxt  = step;
`ifdef IKA87AD_MCSEQ_OVERRUN_TRAP_EN
    overrun_nxt = 1'b0;
`endif
    case (state)
      ST_RESET:   state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (ack_eff) begin
          addr_nxt  = op_eff;
          step_nxt  = 3'd0;
          state_nxt = ST_ROMRD;
        end
      end
      ST_ROMRD:   state_nxt = ST_ROMWAIT;
      ST_ROMWAIT: begin
        mword_nxt = i_MCROM_DATA;
        state_nxt = ST_EXEC;
      end
      ST_EXEC:    state_nxt = ST_BUSWAIT;
      ST_BUSWAIT: begin
        if (ack_eff) begin
          // RD4 ends the instruction and its data is already the next opcode.
          if (bus_code == BUS_RD4) begin
            addr_nxt  = op_eff;
            step_nxt  = 3'd0;
            state_nxt = ST_ROMRD;
          end
`ifdef IKA87AD_MCSEQ_OVERRUN_TRAP_EN
          else if (step == STEP_MAX) begin
            overrun_nxt = 1'b1;
            state_nxt   = ST_FETCH;
          end
`endif
          else begin
            addr_nxt  = addr + 8'd1;
            step_nxt  = (step == STEP_MAX) ? step : step + 3'd1;
            state_nxt = ST_ROMRD;
          end
        end
      end
      default:    state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (i_RST) begin
      state    <= ST_RESET;
      addr     <= 8'h00;
      mword    <= '0;
      step     <= 3'd0;
      ack_pend <= 1'b0;
      op_hold  <= 8'h00;
      outs_q   <= decode_outputs(ST_RESET, BUS_RD4);
`ifdef IKA87AD_MCSEQ_OVERRUN_TRAP_EN
      overrun_q <= 1'b0;
`endif
    end else if (i_CEN) begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      mword    <= mword_nxt;
      step     <= step_nxt;
      ack_pend <= 1'b0;
      outs_q   <= decode_outputs(state_nxt, mword_nxt[MW_BUS_HI:MW_BUS_LO]);
`ifdef IKA87AD_MCSEQ_OVERRUN_TRAP_EN
      overrun_q <= overrun_nxt;
`endif
    end else if (i_BUS_ACK && bus_phase) begin
      ack_pend <= 1'b1;
      op_hold  <= i_OPCODE;
    end
  end

  assign o_MCROM_READ_TICK = outs_q.read_tick;
  assign o_MCROM_ADDR      = addr;
  assign o_BUS_REQ         = outs_q.bus_req;
  assign o_BUS_TYPE        = outs_q.bus_type;
  assign o_UOP             = mword[MW_TYPE_HI:MW_CTRL_LO];
  assign o_UOP_VALID       = outs_q.uop_valid;
  assign o_BUSY            = outs_q.busy;

`ifdef IKA87AD_MCSEQ_OVERRUN_TRAP_EN
  assign o_MC_OVERRUN = overrun_q;
`else
  assign o_MC_OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_ika87ad_mcseq.sv
// Bench for ika87ad_mcseq: table of instructions run against a ROM model, with a
// scoreboard for ROM addresses and micro-ops, plus hand-written reset/trap sequences.
module tb_ika87ad_mcseq;
  import ika87ad_mcseq_pkg::*;

  logic        i_CLK = 1'b0;
  logic        i_RST, i_CEN, i_BUS_ACK;
  logic [7:0]  i_OPCODE;
  logic [17:0] i_MCROM_DATA;
  logic        o_MCROM_READ_TICK, o_BUS_REQ, o_UOP_VALID, o_BUSY, o_MC_OVERRUN;
  logic [7:0]  o_MCROM_ADDR;
  logic [1:0]  o_BUS_TYPE;
  logic [15:0] o_UOP;

  ika87ad_mcseq dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_CEN(i_CEN),
    .o_MCROM_READ_TICK(o_MCROM_READ_TICK), .o_MCROM_ADDR(o_MCROM_ADDR),
    .i_MCROM_DATA(i_MCROM_DATA),
    .o_BUS_REQ(o_BUS_REQ), .o_BUS_TYPE(o_BUS_TYPE), .i_BUS_ACK(i_BUS_ACK),
    .i_OPCODE(i_OPCODE), .o_UOP(o_UOP), .o_UOP_VALID(o_UOP_VALID),
    .o_BUSY(o_BUSY), .o_MC_OVERRUN(o_MC_OVERRUN)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    logic [7:0] op;
    int         hold;
    bit         stray;
    bit         pend;
    int         exp_uops;
    logic [7:0] exp_last;
    bit         exp_trap;
  } vec_t;

`ifdef IKA87AD_MCSEQ_OVERRUN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [17:0] ROM_GARBAGE = 18'h2AAAA;

  int          n_vec = 0;
  int          n_fail = 0;
  int          uop_seen = 0;
  logic [17:0] rom [256];
  logic [7:0]  exp_addr_q [$];
  logic [15:0] exp_uop_q  [$];
  bit          prev_rd = 1'b0;
  logic [7:0]  prev_addr = 8'h00;
  vec_t        vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ROM answers one tick after the strobe and drives garbage otherwise.
  task automatic monitor();
    i_MCROM_DATA = prev_rd ? rom[prev_addr] : ROM_GARBAGE;
    prev_rd   = o_MCROM_READ_TICK;
    prev_addr = o_MCROM_ADDR;
    if (o_MCROM_READ_TICK) begin
      if (exp_addr_q.size() == 0) check("rom_read_unexpected", o_MCROM_READ_TICK, 0);
      else check("rom_addr", o_MCROM_ADDR, exp_addr_q.pop_front());
    end
    if (o_UOP_VALID) begin
      uop_seen++;
      if (exp_uop_q.size() == 0) check("uop_valid_unexpected", o_UOP_VALID, 0);
      else check("uop", o_UOP, exp_uop_q.pop_front());
    end
  endtask

  task automatic tick(input logic cen, input logic ack, input logic [7:0] op);
    @(negedge i_CLK);
    i_CEN = cen; i_BUS_ACK = ack; i_OPCODE = op;
    @(posedge i_CLK);
    #1;
    if (cen && !i_RST) monitor();
  endtask

  // One processor tick, preceded by 0..1 idle clocks with i_CEN low.
  task automatic ctick(input logic ack, input logic [7:0] op);
    int gap = $urandom_range(0, 1);
    repeat (gap) tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, ack, op);
  endtask

  task automatic do_ack(input bit pend, input logic [7:0] op);
    if (pend) begin
      tick(1'b0, 1'b1, op);
      ctick(1'b0, 8'hEE);
    end else begin
      ctick(1'b1, op);
    end
  endtask

  task automatic expect_word(input logic [7:0] a);
    exp_addr_q.push_back(a);
    exp_uop_q.push_back(rom[a][17:2]);
  endtask

  task automatic run_instr(input vec_t v, output logic [7:0] last, output bit trapped);
    logic [7:0] a = v.op;
    logic [2:0] step = 3'd0;
    logic [1:0] code;
    int words = 0;
    last = a;
    trapped = 1'b0;
    check("req_before_opcode", {o_BUS_REQ, o_BUS_TYPE}, {1'b1, BUS_RD4});
    expect_word(a);
    do_ack(v.pend, v.op);
    for (int w = 0; w < 12; w++) begin
      ctick(v.stray, 8'h99);
      ctick(v.stray, 8'h99);
      ctick(v.stray, 8'h99);
      words++;
      code = rom[a][1:0];
      check("buswait_req", o_BUS_REQ, 1);
      check("buswait_type", o_BUS_TYPE, code);
      check("buswait_busy", o_BUSY, 1);
      check("overrun_idle", o_MC_OVERRUN, 0);
      for (int h = 0; h < v.hold; h++) begin
        ctick(1'b0, 8'h00);
        check("hold_req_type", {o_BUS_REQ, o_BUS_TYPE}, {1'b1, code});
        check("hold_no_rom", o_MCROM_READ_TICK, 0);
      end
      last = a;
      if (code == BUS_RD4) return;
      if (TRAP_EN && step == STEP_MAX) begin
        do_ack(v.pend, 8'h00);
        check("overrun_pulse", o_MC_OVERRUN, 1);
        check("trap_fetch", {o_BUS_REQ, o_BUS_TYPE, o_BUSY}, {1'b1, BUS_RD4, 1'b0});
        ctick(1'b0, 8'h00);
        check("overrun_clear", o_MC_OVERRUN, 0);
        check("fetch_wait", {o_BUS_REQ, o_BUS_TYPE}, {1'b1, BUS_RD4});
        trapped = 1'b1;
        return;
      end
      a = a + 8'd1;
      step = (step == STEP_MAX) ? step : step + 3'd1;
      expect_word(a);
      do_ack(v.pend, 8'h55);
    end
    check("word_budget", words, v.exp_uops);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom"}, {o_MCROM_READ_TICK, o_MCROM_ADDR}, 9'h000);
    check({tag, "_bus"}, {o_BUS_REQ, o_BUS_TYPE}, {1'b0, BUS_RD4});
    check({tag, "_uop"}, {o_UOP_VALID, o_UOP}, 17'h0);
    check({tag, "_busy_ovr"}, {o_BUSY, o_MC_OVERRUN}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    logic [7:0] last;
    bit         trapped;
    int         s;

    for (int i = 0; i < 256; i++) rom[i] = {2'b00, 14'h3ABC, BUS_RD4};
    rom[8'h00] = {2'b00, 14'h0001, BUS_RD4};
    rom[8'h40] = {2'b01, 14'h0040, BUS_RD3};
    rom[8'h41] = {2'b01, 14'h0041, BUS_RD4};
    rom[8'hFF] = {2'b10, 14'h3FFF, BUS_WR3};
    rom[8'h20] = {2'b11, 14'h0020, BUS_WR4};
    rom[8'h21] = {2'b11, 14'h0021, BUS_WR3};
    rom[8'h22] = {2'b00, 14'h0022, BUS_RD4};
    for (int i = 0; i < 8; i++) rom[8'h10 + i] = {2'b01, 14'h0010 + 14'(i), BUS_RD3};
    rom[8'h18] = {2'b00, 14'h0018, BUS_RD4};

    //          op     hold stray pend uops last   trap
    vecs[0] = '{8'h00, 0, 1'b0, 1'b0, 1, 8'h00, 1'b0};
    vecs[1] = '{8'h40, 0, 1'b0, 1'b0, 2, 8'h41, 1'b0};
    vecs[2] = '{8'h40, 5, 1'b0, 1'b0, 2, 8'h41, 1'b0};
    vecs[3] = '{8'hFF, 0, 1'b0, 1'b0, 2, 8'h00, 1'b0};
    vecs[4] = '{8'h20, 2, 1'b1, 1'b0, 3, 8'h22, 1'b0};
    vecs[5] = '{8'h40, 0, 1'b0, 1'b1, 2, 8'h41, 1'b0};
    vecs[6] = TRAP_EN ? '{8'h10, 0, 1'b0, 1'b0, 8, 8'h17, 1'b1}
                      : '{8'h10, 0, 1'b0, 1'b0, 9, 8'h18, 1'b0};
    vecs[7] = '{8'h00, 0, 1'b0, 1'b1, 1, 8'h00, 1'b0};

    i_RST = 1'b1; i_CEN = 1'b0; i_BUS_ACK = 1'b0; i_OPCODE = 8'h00;
    i_MCROM_DATA = ROM_GARBAGE;
    repeat (3) @(posedge i_CLK);
    #1;
    check_reset_outputs("reset");

    @(negedge i_CLK);
    i_RST = 1'b0;
    tick(1'b0, 1'b0, 8'h00);
    check("reset_state_idle", {o_BUS_REQ, o_BUSY}, 2'b00);
    ctick(1'b0, 8'h00);
    check("fetch_req", {o_BUS_REQ, o_BUS_TYPE, o_BUSY}, {1'b1, BUS_RD4, 1'b0});

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      s = uop_seen;
      run_instr(v, last, trapped);
      check($sformatf("v%0d_uop_count", i), uop_seen - s, v.exp_uops);
      check($sformatf("v%0d_last_addr", i), last, v.exp_last);
      check($sformatf("v%0d_trap", i), trapped, v.exp_trap);
    end

    // Reset while in BUSWAIT with an ack pending: reset must win.
    expect_word(8'h40);
    do_ack(1'b0, 8'h40);
    ctick(1'b0, 8'h00);
    ctick(1'b0, 8'h00);
    ctick(1'b0, 8'h00);
    check("pre_reset_buswait", {o_BUS_REQ, o_BUS_TYPE}, {1'b1, BUS_RD3});
    tick(1'b0, 1'b1, 8'h77);
    @(negedge i_CLK);
    i_RST = 1'b1; i_CEN = 1'b1; i_BUS_ACK = 1'b1; i_OPCODE = 8'h77;
    @(posedge i_CLK);
    #1;
    check_reset_outputs("midrst");
    prev_rd = 1'b0;
    i_MCROM_DATA = ROM_GARBAGE;
    @(negedge i_CLK);
    i_RST = 1'b0; i_CEN = 1'b0; i_BUS_ACK = 1'b0;
    @(posedge i_CLK);
    #1;
    check("midrst_held", {o_BUS_REQ, o_BUSY, o_UOP_VALID}, 3'b000);
    ctick(1'b0, 8'h00);
    check("midrst_fetch", {o_BUS_REQ, o_BUS_TYPE}, {1'b1, BUS_RD4});
    s = uop_seen;
    run_instr(vecs[0], last, trapped);
    check("midrst_recover_uops", uop_seen - s, 1);

    check("sb_addr_drained", exp_addr_q.size(), 0);
    check("sb_uop_drained", exp_uop_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
